// File: rtl/rgb_pkg.sv
// Shared types and widths for the UART-to-RGB byte unpacker.
// Wire byte order is R, G, B; each pixel is three bytes.
package rgb_pkg;

  localparam int BYTE_W  = 8;
  localparam int PIXEL_W = 24;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  function automatic logic [PIXEL_W-1:0] packPixel(
    input logic [BYTE_W-1:0] red,
    input logic [BYTE_W-1:0] green,
    input logic [BYTE_W-1:0] blue
  );
    return {red, green, blue};
  endfunction

endpackage

// File: rtl/rgb_unpack_idle_timer.sv
// Idle-cycle counter: counts while enabled, and pulses o_expire on the enabled cycle
// where the count has reached timeout_cycles_p-1.
module idle_timer #(
  parameter int timeout_cycles_p = 4096
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CountW = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [CountW-1:0] LastCount = CountW'(timeout_cycles_p - 1);

  logic [CountW-1:0] r_count;

  assign o_expire = i_enable && (r_count == LastCount);

  // Expiry restarts the count so a stuck enable cannot wrap past the limit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CountW'(1);
    end
  end

endmodule

// File: rtl/rgb_unpack.sv
// Assembles UART bytes (R, G, B order) into 24-bit pixels with a valid/ready output,
// end-of-line marking, and discard of partial pixels abandoned for too long.
module rgb_unpack
  import rgb_pkg::*;
#(
  parameter int linewidth_px_p   = 480,
  parameter int timeout_cycles_p = 4096
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [BYTE_W-1:0] red_o,
  output logic [BYTE_W-1:0] green_o,
  output logic [BYTE_W-1:0] blue_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic [7:0]        drop_count_o
);

  localparam int ColW = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(linewidth_px_p - 1);

  phase_e              r_phase;
  phase_e              w_phaseNext;
  logic [BYTE_W-1:0]   r_holdRed;
  logic [BYTE_W-1:0]   r_holdGreen;
  logic [PIXEL_W-1:0]  r_pixel;
  logic                r_valid;
  logic                r_last;
  logic [ColW-1:0]     r_col;
  logic [7:0]          r_dropCount;

  logic                w_accept;
  logic                w_outFire;
  logic                w_loadPixel;
  logic                w_expire;
  logic                w_timerClear;
  logic                w_timerEnable;
  logic [ColW-1:0]     w_colInc;
  logic [ColW-1:0]     w_loadCol;

  // Only the B byte needs output space; R and G go to holding registers.
  assign ready_o     = (r_phase != PH_B) || !r_valid || ready_i;
  assign w_accept    = valid_i && ready_o;
  assign w_outFire   = r_valid && ready_i;
  assign w_loadPixel = w_accept && (r_phase == PH_B);

  assign w_timerClear  = w_accept || (r_phase == PH_R);
  assign w_timerEnable = (r_phase != PH_R) && !w_accept;

  assign w_colInc  = (r_col == LastCol) ? '0 : r_col + ColW'(1);
  assign w_loadCol = w_outFire ? w_colInc : r_col;

  assign valid_o                  = r_valid;
  assign {red_o, green_o, blue_o} = r_pixel;
  assign last_o                   = r_last;
  assign drop_count_o             = r_dropCount;

  idle_timer #(
    .timeout_cycles_p(timeout_cycles_p)
  ) u_idleTimer (
    .i_clk    (clk_i),
    .i_reset  (reset_i),
    .i_clear  (w_timerClear),
    .i_enable (w_timerEnable),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_phase <= PH_R;
    end else begin
      r_phase <= w_phaseNext;
    end
  end

  // Expiry is only possible when no byte is accepted, so an arriving byte always wins.
  always_comb begin
    w_phaseNext = r_phase;
    case (r_phase)
      PH_R: if (w_accept) w_phaseNext = PH_G;
      PH_G: begin
        if (w_accept)      w_phaseNext = PH_B;
        else if (w_expire) w_phaseNext = PH_R;
      end
      PH_B: begin
        if (w_accept)      w_phaseNext = PH_R;
        else if (w_expire) w_phaseNext = PH_R;
      end
      default: w_phaseNext = PH_R;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_holdRed   <= '0;
      r_holdGreen <= '0;
    end else if (w_accept && (r_phase == PH_R)) begin
      r_holdRed <= data_i;
    end else if (w_accept && (r_phase == PH_G)) begin
      r_holdGreen <= data_i;
    end else if (w_expire) begin
      r_holdRed   <= '0;
      r_holdGreen <= '0;
    end
  end

  // A pixel loaded during a handshake takes the column after the one leaving.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pixel <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_loadPixel) begin
      r_pixel <= packPixel(r_holdRed, r_holdGreen, data_i);
      r_last  <= (w_loadCol == LastCol);
      r_valid <= 1'b1;
    end else if (w_outFire) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_col <= '0;
    end else if (w_outFire) begin
      r_col <= w_colInc;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_dropCount <= '0;
    end else if (w_expire && (r_dropCount != 8'hFF)) begin
      r_dropCount <= r_dropCount + 8'd1;
    end
  end

endmodule

// File: doc/rgb_unpack.md
RGB_UNPACK -- requirements
Module: rgb_unpack

Interface
REQ-001 The block SHALL have parameter linewidth_px_p, default 480: pixels per image line.
REQ-002 The block SHALL have parameter timeout_cycles_p, default 4096: idle cycles before a partial pixel is discarded.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-004 The block SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port valid_i  input  1  UART receive byte valid.
REQ-006 The block SHALL have port data_i  input  8  UART receive byte.
REQ-007 The block SHALL have port ready_o  output  1  byte accepted when valid_i && ready_o.
REQ-008 The block SHALL have port valid_o  output  1  assembled pixel valid.
REQ-009 The block SHALL have ports red_o, green_o, blue_o  output  8 each  pixel channels.
REQ-010 The block SHALL have port last_o  output  1  pixel is the final column of its line.
REQ-011 The block SHALL have port ready_i  input  1  downstream (rgb2gray) ready.
REQ-012 The block SHALL have port drop_count_o  output  8  saturating count of discarded partial pixels.

Function
REQ-013 The block SHALL hold byte-phase state PH_R, PH_G, PH_B, with byte order R, G, B on the wire.
REQ-014 In PH_R and PH_G, ready_o SHALL be 1; each accepted byte SHALL load the matching holding register and advance the phase.
REQ-015 In PH_B, ready_o SHALL equal !valid_o || ready_i, with combinational pass-through allowed.
REQ-016 Accepting the B byte SHALL load red_o/green_o/blue_o and last_o, assert valid_o on the next cycle (1-cycle latency), and return to PH_R.
REQ-017 While valid_o && !ready_i, all outputs SHALL be held stable.
REQ-018 valid_o SHALL clear after a valid_o && ready_i handshake unless a new pixel loads in the same cycle.
REQ-019 A column counter SHALL increment on each output handshake and wrap from linewidth_px_p-1 to 0.
REQ-020 last_o SHALL be 1 exactly when the presented pixel's column equals linewidth_px_p-1.
REQ-021 The idle timer SHALL count cycles while the phase is PH_G or PH_B and no byte is accepted.
REQ-022 The idle timer SHALL clear on any byte acceptance and whenever the phase is PH_R.
REQ-023 When the idle timer reaches timeout_cycles_p-1, the phase SHALL return to PH_R, the holding registers SHALL be discarded, and drop_count_o SHALL increment, saturating at 255.
REQ-024 If a byte is accepted in the same cycle the timeout would fire, the byte SHALL win: no discard, timer cleared, phase advances.
REQ-025 A timeout SHALL NOT affect the column counter or a pixel already in the output register.
REQ-026 Pixels SHALL never be dropped or duplicated once the B byte is accepted.

Reset
REQ-027 Asserting reset_i at any time, including mid-pixel, SHALL immediately force: phase PH_R; valid_o=0; red_o/green_o/blue_o=0; last_o=0; column=0; timer=0; drop_count_o=0.
REQ-028 After reset deasserts, ready_o SHALL be 1 on the first cycle.

Structure
REQ-029 The phase enum, byte width (8) and pixel width (24) SHALL live in a shared package, rgb_pkg.
REQ-030 The idle timer SHALL be a sub-module, idle_timer, parameterised by timeout_cycles_p, with clear/enable inputs and a one-cycle expire output.
REQ-031 The block SHALL contain no other sub-modules and no memories.

Verification
REQ-032 Bytes 0x10,0x20,0x30 back-to-back with ready_i=1 -> one beat of red_o=0x10, green_o=0x20, blue_o=0x30, one cycle after the third byte.
REQ-033 Two pixels sent with ready_i=0 -> first pixel held stable, ready_o=0 on the second B byte; raising ready_i delivers both in order, with no loss.
REQ-034 Bytes 0xAA,0xBB, then idle for timeout_cycles_p cycles, then 0x01,0x02,0x03 -> drop_count_o=1 and output pixel (0x01,0x02,0x03).
REQ-035 A G byte arriving exactly on the timeout cycle -> drop_count_o unchanged, and the pixel completes with the next byte.
REQ-036 With linewidth_px_p=4, 9 pixels streamed -> last_o high on pixels 4 and 8 only.
REQ-037 reset_i pulsed after an R byte, then 0x05,0x06,0x07 -> pixel (0x05,0x06,0x07), with drop_count_o=0.
